hazard_ctrl: RTL and testbench

- Pipeline hazard and stall controller for the 5-stage CPU.
- Generates the enable and flush strobes for the PC and the four pipeline registers: if2id, id2ex, ex2mem, mem2wb.
- Resolves four hazard classes:
  - data-memory wait
  - taken branch/jump resolved in EX
  - load-use
  - HI/LO access while the multi-cycle MDU is busy
- Tracks MDU occupancy with an internal timer and keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/hazard_ctrl_mdu_timer.sv | 21 ++
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and constants for the pipeline hazard/stall controller.
package hazard_pkg;
  localparam int TMR_W       = 6;
  localparam int MDU_LAT_DEF = 32;

  typedef enum logic [2:0] {
    CAUSE_NONE = 3'd0,
    CAUSE_MEM  = 3'd1,
    CAUSE_BR   = 3'd2,
    CAUSE_LU   = 3'd3,
    CAUSE_MDU  = 3'd4
  } cause_e;

  typedef struct packed {
    logic pc_en;
    logic if2id_en;
    logic if2id_flush;
    logic id2ex_en;
    logic id2ex_flush;
    logic ex2mem_en;
    logic mem2wb_flush;
  } strobe_t;

  localparam strobe_t STROBE_RUN  = '{pc_en: 1'b1, if2id_en: 1'b1, if2id_flush: 1'b0,
                                      id2ex_en: 1'b1, id2ex_flush: 1'b0,
                                      ex2mem_en: 1'b1, mem2wb_flush: 1'b0};
  localparam strobe_t STROBE_HOLD = '0;
endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// MDU occupancy timer: loads LAT when a mult/div leaves EX, counts down to idle.
module mdu_timer
  import hazard_pkg::*;
#(
  parameter int LAT = MDU_LAT_DEF
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  output logic busy
);
  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk or posedge clr) begin
    if (clr)               tmr <= '0;
    else if (load)         tmr <= TMR_W'(LAT);
    else if (tmr != '0)    tmr <= tmr - TMR_W'(1);
  end

  assign busy = (tmr != '0);
endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage pipeline: priority-resolved strobes,
// MDU occupancy tracking, registered cause and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEF,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_hilo,
  input  logic [4:0]       ex_rt,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             ex_mdu_start,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if2id_en,
  output logic             if2id_flush,
  output logic             id2ex_en,
  output logic             id2ex_flush,
  output logic             ex2mem_en,
  output logic             mem2wb_flush,
  output logic             mdu_busy,
  output logic [2:0]       cause,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  strobe_t st;
  cause_e  cause_nxt, cause_q;
  logic    busy, memwait, loaduse, mduwait;

  assign memwait = mem_req & ~mem_ready;
  assign loaduse = ex_memread & (ex_rt != 5'd0) &
                   ((id_use_rs & (id_rs == ex_rt)) | (id_use_rt & (id_rt == ex_rt)));
  assign mduwait = id_hilo & busy;

  always_comb begin
    st        = STROBE_RUN;
    cause_nxt = CAUSE_NONE;
    if (clr) begin
      st = STROBE_HOLD;
    end else if (memwait) begin
      // whole front end freezes; MEM result is bubbled into WB
      st.pc_en        = 1'b0;
      st.if2id_en     = 1'b0;
      st.id2ex_en     = 1'b0;
      st.ex2mem_en    = 1'b0;
      st.mem2wb_flush = 1'b1;
      cause_nxt       = CAUSE_MEM;
    end else if (ex_branch_taken) begin
      st.if2id_flush  = 1'b1;
      st.id2ex_flush  = 1'b1;
      cause_nxt       = CAUSE_BR;
    end else if (loaduse || mduwait) begin
      st.pc_en        = 1'b0;
      st.if2id_en     = 1'b0;
      st.id2ex_flush  = 1'b1;
      cause_nxt       = loaduse ? CAUSE_LU : CAUSE_MDU;
    end
  end

  assign pc_en        = st.pc_en;
  assign if2id_en     = st.if2id_en;
  assign if2id_flush  = st.if2id_flush;
  assign id2ex_en     = st.id2ex_en;
  assign id2ex_flush  = st.id2ex_flush;
  assign ex2mem_en    = st.ex2mem_en;
  assign mem2wb_flush = st.mem2wb_flush;
  assign mdu_busy     = busy;

  // a mult/div frozen in EX by a memory wait must not arm the timer
  mdu_timer #(.LAT(MDU_LAT)) u_tmr (
    .clk  (clk),
    .clr  (clr),
    .load (ex_mdu_start & st.ex2mem_en),
    .busy (busy)
  );

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cause_q   <= CAUSE_NONE;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      cause_q <= cause_nxt;
      if (!st.pc_en && (stall_cnt != '1))      stall_cnt <= stall_cnt + CNT_W'(1);
      if (st.if2id_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  assign cause = cause_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MDU_LAT=4, CNT_W=4) with hand-computed expectations.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       clr;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_use_rs, id_use_rt, id_hilo, ex_memread, ex_branch_taken, ex_mdu_start;
  logic       mem_req, mem_ready;
  logic       pc_en, if2id_en, if2id_flush, id2ex_en, id2ex_flush, ex2mem_en, mem2wb_flush, mdu_busy;
  logic [2:0] cause;
  logic [3:0] stall_cnt, flush_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .clr(clr),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_hilo(id_hilo),
    .ex_rt(ex_rt), .ex_memread(ex_memread), .ex_branch_taken(ex_branch_taken), .ex_mdu_start(ex_mdu_start),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if2id_en(if2id_en), .if2id_flush(if2id_flush), .id2ex_en(id2ex_en),
    .id2ex_flush(id2ex_flush), .ex2mem_en(ex2mem_en), .mem2wb_flush(mem2wb_flush),
    .mdu_busy(mdu_busy), .cause(cause), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_hilo = 1'b0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0; ex_mdu_start = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    clr = 1'b1;
    cyc(); cyc();
    clr = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    clr = 1'b1;
    #3;
    n_chk++; if ({pc_en, if2id_en, id2ex_en, ex2mem_en} !== 4'b0000) begin n_fail++; $display("FAIL rst_en got %b exp 0000", {pc_en, if2id_en, id2ex_en, ex2mem_en}); end
    n_chk++; if ({if2id_flush, id2ex_flush, mem2wb_flush, mdu_busy} !== 4'b0000) begin n_fail++; $display("FAIL rst_flush got %b exp 0000", {if2id_flush, id2ex_flush, mem2wb_flush, mdu_busy}); end
    cyc();
    n_chk++; if ({cause, stall_cnt, flush_cnt} !== 11'd0) begin n_fail++; $display("FAIL rst_regs got %0d/%0d/%0d exp 0/0/0", cause, stall_cnt, flush_cnt); end
    clr = 1'b0;
    #1;
    n_chk++; if ({pc_en, if2id_en, id2ex_en, ex2mem_en, if2id_flush, id2ex_flush, mem2wb_flush} !== 7'b1111000) begin n_fail++; $display("FAIL idle_strobes got %b exp 1111000", {pc_en, if2id_en, id2ex_en, ex2mem_en, if2id_flush, id2ex_flush, mem2wb_flush}); end
    cyc();
    n_chk++; if (stall_cnt !== 4'd0) begin n_fail++; $display("FAIL idle_stall_cnt got %0d exp 0", stall_cnt); end
  endtask

  task automatic test_loaduse();
    do_reset();
    ex_memread = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    #1;
    n_chk++; if ({pc_en, if2id_en, id2ex_flush, id2ex_en} !== 4'b0011) begin n_fail++; $display("FAIL lu_strobes got %b exp 0011", {pc_en, if2id_en, id2ex_flush, id2ex_en}); end
    cyc();
    idle_inputs();
    #1;
    n_chk++; if (cause !== 3'd3) begin n_fail++; $display("FAIL lu_cause got %0d exp 3", cause); end
    n_chk++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL lu_stall_cnt got %0d exp 1", stall_cnt); end
    n_chk++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_release got %b exp 1", pc_en); end
    // rt field match via id_use_rt, destination r0 never hazards
    ex_memread = 1'b1; ex_rt = 5'd0; id_rt = 5'd0; id_use_rt = 1'b1;
    #1;
    n_chk++; if ({pc_en, id2ex_flush} !== 2'b10) begin n_fail++; $display("FAIL lu_r0 got %b exp 10", {pc_en, id2ex_flush}); end
    cyc();
    n_chk++; if ({cause, stall_cnt} !== {3'd0, 4'd1}) begin n_fail++; $display("FAIL lu_r0_regs got %0d/%0d exp 0/1", cause, stall_cnt); end
    ex_rt = 5'd5; id_rt = 5'd5;
    #1;
    n_chk++; if ({pc_en, if2id_en, id2ex_flush} !== 3'b001) begin n_fail++; $display("FAIL lu_rt got %b exp 001", {pc_en, if2id_en, id2ex_flush}); end
    id_use_rt = 1'b0;
    #1;
    n_chk++; if (pc_en !== 1'b1) begin n_fail++; $display("FAIL lu_nouse got %b exp 1", pc_en); end
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    ex_branch_taken = 1'b1;
    #1;
    n_chk++; if ({if2id_flush, id2ex_flush, pc_en, mem2wb_flush} !== 4'b1110) begin n_fail++; $display("FAIL br_strobes got %b exp 1110", {if2id_flush, id2ex_flush, pc_en, mem2wb_flush}); end
    cyc();
    idle_inputs();
    #1;
    n_chk++; if ({cause, flush_cnt, stall_cnt} !== {3'd2, 4'd1, 4'd0}) begin n_fail++; $display("FAIL br_regs got %0d/%0d/%0d exp 2/1/0", cause, flush_cnt, stall_cnt); end
  endtask

  task automatic test_priority();
    do_reset();
    // branch beats load-use
    ex_branch_taken = 1'b1; ex_memread = 1'b1; ex_rt = 5'd3; id_rs = 5'd3; id_use_rs = 1'b1;
    #1;
    n_chk++; if ({pc_en, if2id_flush, id2ex_flush} !== 3'b111) begin n_fail++; $display("FAIL pri_br_lu got %b exp 111", {pc_en, if2id_flush, id2ex_flush}); end
    cyc();
    n_chk++; if (cause !== 3'd2) begin n_fail++; $display("FAIL pri_br_cause got %0d exp 2", cause); end
    idle_inputs();
  endtask

  task automatic test_memwait();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_chk++; if ({pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_flush, if2id_flush, id2ex_flush} !== 7'b0000100) begin n_fail++; $display("FAIL mw_strobes[%0d] got %b exp 0000100", i, {pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_flush, if2id_flush, id2ex_flush}); end
      cyc();
      n_chk++; if (cause !== 3'd1) begin n_fail++; $display("FAIL mw_cause[%0d] got %0d exp 1", i, cause); end
    end
    mem_ready = 1'b1;
    #1;
    n_chk++; if ({pc_en, if2id_flush, id2ex_flush, mem2wb_flush} !== 4'b1110) begin n_fail++; $display("FAIL mw_br_release got %b exp 1110", {pc_en, if2id_flush, id2ex_flush, mem2wb_flush}); end
    cyc();
    idle_inputs();
    #1;
    n_chk++; if ({cause, stall_cnt, flush_cnt} !== {3'd2, 4'd3, 4'd1}) begin n_fail++; $display("FAIL mw_regs got %0d/%0d/%0d exp 2/3/1", cause, stall_cnt, flush_cnt); end
  endtask

  task automatic test_mdu();
    do_reset();
    ex_mdu_start = 1'b1;
    #1;
    n_chk++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL mdu_prestart got %b exp 0", mdu_busy); end
    cyc();
    ex_mdu_start = 1'b0; id_hilo = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_chk++; if ({mdu_busy, pc_en, if2id_en, id2ex_flush} !== 4'b1001) begin n_fail++; $display("FAIL mdu_stall[%0d] got %b exp 1001", i, {mdu_busy, pc_en, if2id_en, id2ex_flush}); end
      cyc();
      n_chk++; if (cause !== 3'd4) begin n_fail++; $display("FAIL mdu_cause[%0d] got %0d exp 4", i, cause); end
    end
    #1;
    n_chk++; if ({mdu_busy, pc_en, id2ex_flush} !== 3'b010) begin n_fail++; $display("FAIL mdu_release got %b exp 010", {mdu_busy, pc_en, id2ex_flush}); end
    cyc();
    n_chk++; if ({cause, stall_cnt} !== {3'd0, 4'd4}) begin n_fail++; $display("FAIL mdu_regs got %0d/%0d exp 0/4", cause, stall_cnt); end
    idle_inputs();
    // a start frozen by a memory wait must not arm the timer
    mem_req = 1'b1; ex_mdu_start = 1'b1;
    cyc();
    idle_inputs();
    #1;
    n_chk++; if (mdu_busy !== 1'b0) begin n_fail++; $display("FAIL mdu_frozen_start got %b exp 0", mdu_busy); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ex_mdu_start = 1'b1;
    cyc();
    ex_mdu_start = 1'b0; id_hilo = 1'b1;
    cyc(); cyc();
    n_chk++; if ({mdu_busy, cause, stall_cnt} !== {1'b1, 3'd4, 4'd2}) begin n_fail++; $display("FAIL ar_pre got %b/%0d/%0d exp 1/4/2", mdu_busy, cause, stall_cnt); end
    #2 clr = 1'b1;
    #1;
    n_chk++; if ({mdu_busy, cause, stall_cnt, flush_cnt} !== 12'd0) begin n_fail++; $display("FAIL ar_clear got %b/%0d/%0d/%0d exp 0/0/0/0", mdu_busy, cause, stall_cnt, flush_cnt); end
    n_chk++; if ({pc_en, if2id_en, id2ex_flush} !== 3'b000) begin n_fail++; $display("FAIL ar_strobes got %b exp 000", {pc_en, if2id_en, id2ex_flush}); end
    #2 clr = 1'b0;
    #1;
    n_chk++; if ({pc_en, if2id_en, id2ex_flush} !== 3'b110) begin n_fail++; $display("FAIL ar_nostall got %b exp 110", {pc_en, if2id_en, id2ex_flush}); end
    cyc();
    n_chk++; if ({cause, stall_cnt, mdu_busy} !== 8'd0) begin n_fail++; $display("FAIL ar_after got %0d/%0d/%b exp 0/0/0", cause, stall_cnt, mdu_busy); end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    mem_req = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc();
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d exp 15", stall_cnt); end
    for (int i = 0; i < 5; i++) cyc();
    n_chk++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d exp 15", stall_cnt); end
    idle_inputs();
    // 20 taken branches: flush counter saturates too
    ex_branch_taken = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    n_chk++; if (flush_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_flush got %0d exp 15", flush_cnt); end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    clr = 1'b1;
    test_reset();
    test_loaduse();
    test_branch();
    test_priority();
    test_memwait();
    test_mdu();
    test_async_reset();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
